eth_idma_desc_sched: RTL and testbench



---
 rtl/eth_idma_desc_sched.sv | 203 ++++++++++++++++++++
 tb/tb_eth_idma_desc_sched.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_idma_desc_sched.sv
// Ethernet iDMA descriptor scheduler: TX/RX descriptor FIFOs, round-robin arbitration and a
// single-outstanding iDMA request/response FSM with completion counters and a sticky error.

module eth_idma_desc_sched #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned LenWidth   = 32,
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 tx_desc_valid_i,
    output logic                 tx_desc_ready_o,
    input  logic [AddrWidth-1:0] tx_desc_addr_i,
    input  logic [LenWidth-1:0]  tx_desc_len_i,

    input  logic                 rx_desc_valid_i,
    output logic                 rx_desc_ready_o,
    input  logic [AddrWidth-1:0] rx_desc_addr_i,
    input  logic [LenWidth-1:0]  rx_desc_len_i,

    output logic                 idma_req_valid_o,
    input  logic                 idma_req_ready_i,
    output logic [AddrWidth-1:0] idma_src_addr_o,
    output logic [AddrWidth-1:0] idma_dst_addr_o,
    output logic [LenWidth-1:0]  idma_len_o,
    output logic                 idma_dir_o,

    input  logic                 idma_rsp_valid_i,
    output logic                 idma_rsp_ready_o,
    input  logic                 idma_rsp_error_i,

    output logic                 tx_done_o,
    output logic                 rx_done_o,
    output logic [CntWidth-1:0]  tx_cnt_o,
    output logic [CntWidth-1:0]  rx_cnt_o,

    output logic                 err_o,
    input  logic                 clr_err_i,
    output logic                 busy_o
);

    localparam int unsigned     PtrW   = $clog2(QueueDepth);
    localparam logic [PtrW:0]   PtrInc = (PtrW + 1)'(1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StSkip} state_e;

    state_e state_q;

    // Descriptor storage; pointers carry an extra wrap bit to tell full from empty.
    logic [AddrWidth-1:0] tx_addr_mem [QueueDepth];
    logic [LenWidth-1:0]  tx_len_mem  [QueueDepth];
    logic [AddrWidth-1:0] rx_addr_mem [QueueDepth];
    logic [LenWidth-1:0]  rx_len_mem  [QueueDepth];
    logic [PtrW:0]        tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;

    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic grant_tx, grant_rx, last_tx_q;

    logic [AddrWidth-1:0] head_addr;
    logic [LenWidth-1:0]  head_len;

    logic                 req_valid_q, rsp_ready_q, dir_q;
    logic [AddrWidth-1:0] src_q, dst_q;
    logic [LenWidth-1:0]  len_q;
    logic                 tx_done_q, rx_done_q, err_q;
    logic [CntWidth-1:0]  tx_cnt_q, rx_cnt_q;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign tx_full  = (tx_wr_q[PtrW] != tx_rd_q[PtrW]) &&
                      (tx_wr_q[PtrW-1:0] == tx_rd_q[PtrW-1:0]);
    assign rx_full  = (rx_wr_q[PtrW] != rx_rd_q[PtrW]) &&
                      (rx_wr_q[PtrW-1:0] == rx_rd_q[PtrW-1:0]);

    assign tx_desc_ready_o = !tx_full;
    assign rx_desc_ready_o = !rx_full;
    assign tx_push = tx_desc_valid_i && !tx_full;
    assign rx_push = rx_desc_valid_i && !rx_full;

    // TX wins when it did not win last time or RX has nothing queued.
    assign grant_tx = (state_q == StIdle) && !tx_empty && (rx_empty || !last_tx_q);
    assign grant_rx = (state_q == StIdle) && !rx_empty && !grant_tx;
    assign tx_pop   = grant_tx;
    assign rx_pop   = grant_rx;

    assign head_addr = grant_tx ? tx_addr_mem[tx_rd_q[PtrW-1:0]] : rx_addr_mem[rx_rd_q[PtrW-1:0]];
    assign head_len  = grant_tx ? tx_len_mem[tx_rd_q[PtrW-1:0]]  : rx_len_mem[rx_rd_q[PtrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_addr_mem[tx_wr_q[PtrW-1:0]] <= tx_desc_addr_i;
            tx_len_mem[tx_wr_q[PtrW-1:0]]  <= tx_desc_len_i;
        end
        if (rx_push) begin
            rx_addr_mem[rx_wr_q[PtrW-1:0]] <= rx_desc_addr_i;
            rx_len_mem[rx_wr_q[PtrW-1:0]]  <= rx_desc_len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PtrInc;
            if (tx_pop)  tx_rd_q <= tx_rd_q + PtrInc;
            if (rx_push) rx_wr_q <= rx_wr_q + PtrInc;
            if (rx_pop)  rx_rd_q <= rx_rd_q + PtrInc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            last_tx_q   <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            dir_q       <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            // An error response later in this block overrides the clear.
            if (clr_err_i) err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_tx || grant_rx) begin
                        last_tx_q <= grant_tx;
                        dir_q     <= grant_rx;
                        src_q     <= grant_tx ? head_addr : '0;
                        dst_q     <= grant_rx ? head_addr : '0;
                        len_q     <= head_len;
                        if (head_len == '0) begin
                            state_q <= StSkip;
                        end else begin
                            state_q     <= StIssue;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (idma_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (idma_rsp_valid_i) begin
                        rsp_ready_q <= 1'b0;
                        if (dir_q) begin
                            rx_done_q <= 1'b1;
                            rx_cnt_q  <= rx_cnt_q + CntOne;
                        end else begin
                            tx_done_q <= 1'b1;
                            tx_cnt_q  <= tx_cnt_q + CntOne;
                        end
                        if (idma_rsp_error_i) err_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StSkip: begin
                    if (dir_q) begin
                        rx_done_q <= 1'b1;
                        rx_cnt_q  <= rx_cnt_q + CntOne;
                    end else begin
                        tx_done_q <= 1'b1;
                        tx_cnt_q  <= tx_cnt_q + CntOne;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign idma_req_valid_o = req_valid_q;
    assign idma_src_addr_o  = src_q;
    assign idma_dst_addr_o  = dst_q;
    assign idma_len_o       = len_q;
    assign idma_dir_o       = dir_q;
    assign idma_rsp_ready_o = rsp_ready_q;
    assign tx_done_o        = tx_done_q;
    assign rx_done_o        = rx_done_q;
    assign tx_cnt_o         = tx_cnt_q;
    assign rx_cnt_o         = rx_cnt_q;
    assign err_o            = err_q;
    assign busy_o           = (state_q != StIdle) || !tx_empty || !rx_empty;

endmodule

// File: tb/tb_eth_idma_desc_sched.sv
// Bench for eth_idma_desc_sched: directed scenarios plus randomized rounds checked against a
// queue-based round-robin reference model.

module tb_eth_idma_desc_sched;

    localparam int AW = 32;
    localparam int LW = 32;
    localparam int QD = 4;
    localparam int CW = 8;
    localparam int unsigned CntMod = 1 << CW;

    typedef struct packed {
        logic          dir;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } desc_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_desc_valid, tx_desc_ready, rx_desc_valid, rx_desc_ready;
    logic [AW-1:0] tx_desc_addr, rx_desc_addr, idma_src_addr, idma_dst_addr;
    logic [LW-1:0] tx_desc_len, rx_desc_len, idma_len;
    logic          idma_req_valid, idma_req_ready, idma_dir;
    logic          idma_rsp_valid, idma_rsp_ready, idma_rsp_error;
    logic          tx_done, rx_done, err, clr_err, busy;
    logic [CW-1:0] tx_cnt, rx_cnt;

    eth_idma_desc_sched #(
        .AddrWidth (AW),
        .LenWidth  (LW),
        .QueueDepth(QD),
        .CntWidth  (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .tx_desc_valid_i (tx_desc_valid),
        .tx_desc_ready_o (tx_desc_ready),
        .tx_desc_addr_i  (tx_desc_addr),
        .tx_desc_len_i   (tx_desc_len),
        .rx_desc_valid_i (rx_desc_valid),
        .rx_desc_ready_o (rx_desc_ready),
        .rx_desc_addr_i  (rx_desc_addr),
        .rx_desc_len_i   (rx_desc_len),
        .idma_req_valid_o(idma_req_valid),
        .idma_req_ready_i(idma_req_ready),
        .idma_src_addr_o (idma_src_addr),
        .idma_dst_addr_o (idma_dst_addr),
        .idma_len_o      (idma_len),
        .idma_dir_o      (idma_dir),
        .idma_rsp_valid_i(idma_rsp_valid),
        .idma_rsp_ready_o(idma_rsp_ready),
        .idma_rsp_error_i(idma_rsp_error),
        .tx_done_o       (tx_done),
        .rx_done_o       (rx_done),
        .tx_cnt_o        (tx_cnt),
        .rx_cnt_o        (rx_cnt),
        .err_o           (err),
        .clr_err_i       (clr_err),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: descriptor queues, round-robin memory, counters, sticky error.
    desc_t       mq_tx[$];
    desc_t       mq_rx[$];
    bit          m_last_rx;
    int unsigned m_tx_cnt, m_rx_cnt;
    bit          m_err;
    logic [15:0] dir_log;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t pick();
        desc_t d;
        if (mq_tx.size() != 0 && (mq_rx.size() == 0 || m_last_rx)) begin
            d = mq_tx.pop_front();
            m_last_rx = 1'b0;
        end else begin
            d = mq_rx.pop_front();
            m_last_rx = 1'b1;
        end
        return d;
    endfunction

    function automatic desc_t mk(input logic dir, input logic [AW-1:0] addr,
                                 input logic [LW-1:0] len);
        desc_t d;
        d.dir  = dir;
        d.addr = addr;
        d.len  = len;
        return d;
    endfunction

    task automatic check_cnts();
        check("tx_cnt", tx_cnt, m_tx_cnt);
        check("rx_cnt", rx_cnt, m_rx_cnt);
    endtask

    task automatic check_reset_values();
        check("rst_req_valid", idma_req_valid, 0);
        check("rst_rsp_ready", idma_rsp_ready, 0);
        check("rst_src", idma_src_addr, 0);
        check("rst_dst", idma_dst_addr, 0);
        check("rst_len", idma_len, 0);
        check("rst_dir", idma_dir, 0);
        check("rst_done", {tx_done, rx_done}, 0);
        check("rst_tx_cnt", tx_cnt, 0);
        check("rst_rx_cnt", rx_cnt, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_desc_ready", {tx_desc_ready, rx_desc_ready}, 2'b11);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_desc_valid = 1'b0;
        rx_desc_valid = 1'b0;
        idma_req_ready = 1'b0;
        idma_rsp_valid = 1'b0;
        idma_rsp_error = 1'b0;
        clr_err = 1'b0;
        tick();
        check_reset_values();
        rst_n = 1'b1;
        mq_tx.delete();
        mq_rx.delete();
        m_last_rx = 1'b1;
        m_tx_cnt = 0;
        m_rx_cnt = 0;
        m_err = 1'b0;
    endtask

    // One clock of descriptor pushes; pop_now marks the edge at which the DUT arbitrates.
    task automatic step(input bit tv, input desc_t td, input bit rv, input desc_t rd,
                        input bit pop_now, output desc_t cur);
        bit at, ar;
        check("tx_desc_ready", tx_desc_ready, mq_tx.size() < QD);
        check("rx_desc_ready", rx_desc_ready, mq_rx.size() < QD);
        tx_desc_valid = tv;
        tx_desc_addr  = td.addr;
        tx_desc_len   = td.len;
        rx_desc_valid = rv;
        rx_desc_addr  = rd.addr;
        rx_desc_len   = rd.len;
        at = tv && (mq_tx.size() < QD);
        ar = rv && (mq_rx.size() < QD);
        tick();
        tx_desc_valid = 1'b0;
        rx_desc_valid = 1'b0;
        cur = '0;
        if (pop_now) cur = pick();
        if (at) mq_tx.push_back(td);
        if (ar) mq_rx.push_back(rd);
    endtask

    task automatic complete(input logic dir);
        if (dir) m_rx_cnt = (m_rx_cnt + 1) % CntMod;
        else     m_tx_cnt = (m_tx_cnt + 1) % CntMod;
    endtask

    // Called with the request for d already visible on the iDMA port.
    task automatic do_transfer(input desc_t d, input int rdly, input int sdly,
                               input bit e, input bit clr);
        logic [AW-1:0] esrc, edst;
        esrc = d.dir ? '0 : d.addr;
        edst = d.dir ? d.addr : '0;
        dir_log = {dir_log[14:0], idma_dir};
        check("req_valid", idma_req_valid, 1);
        check("req_src", idma_src_addr, esrc);
        check("req_dst", idma_dst_addr, edst);
        check("req_len", idma_len, d.len);
        check("req_dir", idma_dir, d.dir);
        check("busy_xfer", busy, 1);
        for (int k = 0; k < rdly; k++) begin
            idma_rsp_valid = 1'($urandom_range(0, 1));
            idma_rsp_error = 1'($urandom_range(0, 1));
            tick();
            check("req_held", idma_req_valid, 1);
            check("req_src_stable", idma_src_addr, esrc);
            check("no_done_issue", {tx_done, rx_done}, 0);
        end
        idma_rsp_valid = 1'b0;
        idma_rsp_error = 1'b0;
        idma_req_ready = 1'b1;
        tick();
        idma_req_ready = 1'b0;
        check("req_dropped", idma_req_valid, 0);
        check("rsp_ready", idma_rsp_ready, 1);
        for (int k = 0; k < sdly; k++) begin
            tick();
            check("rsp_ready_wait", idma_rsp_ready, 1);
            check("no_done_wait", {tx_done, rx_done}, 0);
        end
        idma_rsp_valid = 1'b1;
        idma_rsp_error = e;
        clr_err = clr;
        tick();
        idma_rsp_valid = 1'b0;
        idma_rsp_error = 1'b0;
        clr_err = 1'b0;
        complete(d.dir);
        if (e) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        check("done_pulse", {tx_done, rx_done}, d.dir ? 2'b01 : 2'b10);
        check_cnts();
        check("err", err, m_err);
        check("rsp_ready_low", idma_rsp_ready, 0);
    endtask

    task automatic wait_event(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (idma_req_valid || tx_done || rx_done) found = 1'b1;
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL event_timeout: observed no request/done expected one within 20 cycles");
        end
    endtask

    task automatic handle_item(input desc_t d);
        bit found;
        wait_event(found);
        if (!found) return;
        if (d.len == '0) begin
            check("skip_no_req", idma_req_valid, 0);
            check("skip_done", {tx_done, rx_done}, d.dir ? 2'b01 : 2'b10);
            complete(d.dir);
            check_cnts();
        end else begin
            check("req_seen", idma_req_valid, 1);
            do_transfer(d, $urandom_range(0, 3), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic run_order();
        desc_t d;
        while (mq_tx.size() != 0 || mq_rx.size() != 0) begin
            d = pick();
            handle_item(d);
        end
    endtask

    function automatic desc_t rand_desc(input logic dir, input bit allow_zero);
        logic [LW-1:0] len;
        if (allow_zero && $urandom_range(0, 3) == 0) len = '0;
        else len = LW'($urandom_range(1, 4096));
        return mk(dir, $urandom, len);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        desc_t z, cur, cur0, d0, dt, dr;
        desc_t tl[QD], rl[QD];
        int nt, nr;
        z = '0;
        dir_log = '0;

        // Reset state, then a single TX transfer with the iDMA ready from the start.
        do_reset();
        idma_req_ready = 1'b1;
        step(1, mk(0, 32'h1000, 32'd64), 0, z, 0, cur);
        check("lat_n1", idma_req_valid, 0);
        step(0, z, 0, z, 1, cur);
        check("lat_n2", idma_req_valid, 1);
        do_transfer(cur, 0, 0, 0, 0);
        check("tx_cnt_one", tx_cnt, 1);
        tick();
        check("tx_done_one_pulse", tx_done, 0);
        check("busy_idle", busy, 0);

        // Three descriptors per queue: strict alternation starting with TX.
        do_reset();
        dir_log = '0;
        for (int i = 0; i < 3; i++) begin
            tl[i] = rand_desc(0, 0);
            rl[i] = rand_desc(1, 0);
        end
        step(1, tl[0], 1, rl[0], 0, cur);
        step(1, tl[1], 1, rl[1], 1, cur0);
        step(1, tl[2], 1, rl[2], 0, cur);
        do_transfer(cur0, 1, 0, 0, 0);
        run_order();
        check("grant_order", dir_log[5:0], 6'b010101);

        // Fill the TX queue behind a stalled transfer; the next push only lands after a pop.
        do_reset();
        step(1, rand_desc(0, 0), 0, z, 0, cur);
        step(0, z, 0, z, 1, cur0);
        for (int i = 0; i < QD + 2; i++) step(1, rand_desc(0, 0), 0, z, 0, cur);
        check("tx_full_ready", tx_desc_ready, 0);
        do_transfer(cur0, 1, 1, 0, 0);
        dt = rand_desc(0, 0);
        step(1, dt, 0, z, 1, cur);
        check("tx_ready_after_pop", tx_desc_ready, 1);
        step(1, dt, 0, z, 0, cur0);
        check("tx_refull", tx_desc_ready, 0);
        do_transfer(cur, 0, 2, 0, 0);
        run_order();

        // Zero-length RX descriptor completes without an iDMA request.
        do_reset();
        step(0, z, 1, mk(1, $urandom, '0), 0, cur);
        step(0, z, 0, z, 1, cur);
        check("skip_req_low", idma_req_valid, 0);
        handle_item(cur);
        check("rx_cnt_one", rx_cnt, 1);

        // Sticky error, explicit clear, and set winning over a simultaneous clear.
        do_reset();
        step(1, rand_desc(0, 0), 0, z, 0, cur);
        step(0, z, 0, z, 1, cur);
        do_transfer(cur, 1, 1, 1, 0);
        tick();
        tick();
        check("err_held", err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_err = 1'b0;
        check("err_cleared", err, 0);
        step(0, z, 1, rand_desc(1, 0), 0, cur);
        step(0, z, 0, z, 1, cur);
        do_transfer(cur, 0, 0, 1, 1);
        check("err_set_wins", err, 1);

        // Counter wrap-around through back-to-back zero-length completions.
        do_reset();
        for (int i = 0; i < int'(CntMod); i++) begin
            step(1, mk(0, $urandom, '0), 0, z, 0, cur);
            step(0, z, 0, z, 1, cur);
            handle_item(cur);
            if (i == int'(CntMod) - 2) check("cnt_at_max", tx_cnt, CntMod - 1);
        end
        check("cnt_wrapped", tx_cnt, 0);

        // Reset while waiting for the response: everything returns to reset values.
        do_reset();
        step(1, rand_desc(0, 0), 0, z, 0, cur);
        step(1, rand_desc(0, 0), 0, z, 1, cur);
        idma_req_ready = 1'b1;
        tick();
        idma_req_ready = 1'b0;
        check("in_wait_rsp", idma_rsp_ready, 1);
        do_reset();
        idma_rsp_valid = 1'b1;
        idma_rsp_error = 1'b1;
        tick();
        idma_rsp_valid = 1'b0;
        idma_rsp_error = 1'b0;
        check("late_rsp_no_done", {tx_done, rx_done}, 0);
        check_cnts();
        check("late_rsp_no_err", err, 0);
        tick();
        tick();
        check("post_rst_no_req", idma_req_valid, 0);
        check("post_rst_idle", busy, 0);

        // Randomized rounds: one stalled transfer, then a random mix of queued descriptors.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            d0 = rand_desc(1'($urandom_range(0, 1)), 0);
            nt = $urandom_range(0, QD);
            nr = $urandom_range(0, QD);
            for (int i = 0; i < QD; i++) begin
                tl[i] = rand_desc(0, 1);
                rl[i] = rand_desc(1, 1);
            end
            step(!d0.dir, d0, d0.dir, d0, 0, cur);
            check("rnd_lat_n1", idma_req_valid, 0);
            for (int i = 0; i < QD; i++) begin
                dt = tl[i];
                dr = rl[i];
                step(i < nt, dt, i < nr, dr, i == 0, cur);
                if (i == 0) begin
                    cur0 = cur;
                    check("rnd_lat_n2", idma_req_valid, 1);
                end
            end
            do_transfer(cur0, $urandom_range(0, 3), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b0);
            run_order();
            check("rnd_idle", busy, 0);
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            m_err = 1'b0;
            check("rnd_err_clr", err, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
